ram_stream_reader: RTL

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_reader
// Description : Bursts words from a synchronous RAM read port into a 2-entry
//               FIFO and presents them on a valid/ready stream.
//               Optional m_par output built when RD_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_reader #(
    parameter int AW = 6,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic [AW-1:0] dpra,
    input  logic [DW-1:0] dpo,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          done
`ifdef RD_PARITY_EN
    ,
    output logic          m_par
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0]   c_max_len  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_len_one  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_addr_one = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] dpra_q;
    logic [AW:0]   issue_left_q, issue_left_d;
    logic [AW:0]   xfer_left_q, xfer_left_d;
    logic          zdone_q, zdone_d;
    logic          inflight_q;
    logic [DW-1:0] fifo_q [0:1];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    occ_q;

    logic [AW:0]   w_eff_len;
    logic          w_pop;
    logic          w_room;
    logic          w_issue;
    logic [AW-1:0] w_issue_addr;
    logic          w_last;

    assign w_eff_len = (len > c_max_len) ? c_max_len : len;
    assign m_valid   = (occ_q != 2'd0);
    assign w_pop     = m_valid && m_ready;

    // Occupancy is counted after this cycle's pop so a steady stream keeps one
    // read issued per cycle; the FIFO plus the in-flight read never exceeds 2.
    assign w_room = (({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, w_pop}) < 3'd2;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        xfer_left_d  = w_pop ? (xfer_left_q - c_len_one) : xfer_left_q;
        zdone_d      = 1'b0;
        w_issue      = 1'b0;
        w_issue_addr = addr_q;
        w_last       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (w_eff_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        // First read goes out in the start cycle itself.
                        w_issue      = 1'b1;
                        w_issue_addr = base_addr;
                        addr_d       = base_addr + c_addr_one;
                        issue_left_d = w_eff_len - c_len_one;
                        xfer_left_d  = w_eff_len;
                        state_d      = (w_eff_len == c_len_one) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if (issue_left_q == '0) begin
                    state_d = S_DRAIN;
                end else if (w_room) begin
                    w_issue      = 1'b1;
                    addr_d       = addr_q + c_addr_one;
                    issue_left_d = issue_left_q - c_len_one;
                    if (issue_left_q == c_len_one) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && (xfer_left_q == c_len_one)) begin
                    w_last  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            dpra_q       <= '0;
            issue_left_q <= '0;
            xfer_left_q  <= '0;
            zdone_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            dpra_q       <= dpra;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            zdone_q      <= zdone_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= dpo;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q      <= (occ_q + {1'b0, inflight_q}) - {1'b0, w_pop};
            inflight_q <= w_issue;
        end
    end

    // The RAM registers dpra, so a new address must be visible in its issue cycle.
    assign dpra   = w_issue ? w_issue_addr : dpra_q;
    assign m_data = fifo_q[rd_ptr_q];
    assign busy   = (state_q != S_IDLE);
    assign done   = w_last | zdone_q;

`ifdef RD_PARITY_EN
    assign m_par = ^m_data;
`endif

endmodule
`default_nettype wire
